// File: rtl/booth_divider.sv
// Sequential signed restoring divider sharing the serial Booth multiplier's bus protocol:
// dividend then divisor on inbus, quotient then remainder on outbus qualified by done.
module booth_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] inbus,
    output logic             done,
    output logic [WIDTH-1:0] outbus,
    output logic             busy,
    output logic             dbz,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_M,
        S_ITER,
        S_FIX,
        S_OUT_Q,
        S_OUT_R
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CW-1:0]    r_cnt;
    logic             r_sq;
    logic             r_sm;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic             r_done;
    logic [WIDTH-1:0] r_outbus;
    logic             r_busy;
    logic             r_dbz;
    logic             r_ovf;

    logic [WIDTH-1:0] w_in_mag;
    logic [WIDTH:0]   w_a_sh;
    logic [WIDTH:0]   w_t;
    logic [WIDTH-1:0] w_a_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_min;
    logic [WIDTH-1:0] w_one;
    logic             w_ovf;

    // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is exact as unsigned.
    assign w_in_mag = inbus[WIDTH-1] ? -inbus : inbus;

    assign w_a_sh = {r_a, r_q[WIDTH-1]};
    assign w_t    = w_a_sh - {1'b0, r_m};
    assign w_a_nx = w_t[WIDTH] ? w_a_sh[WIDTH-1:0] : w_t[WIDTH-1:0];
    assign w_q_nx = {r_q[WIDTH-2:0], ~w_t[WIDTH]};

    assign w_quo = (r_sq ^ r_sm) ? -r_q : r_q;
    assign w_rem = r_sq ? -r_a : r_a;
    assign w_min = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_one = {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_ovf = (r_dvd == w_min) && r_sm && (r_m == w_one);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_sq     <= 1'b0;
            r_sm     <= 1'b0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_done   <= 1'b0;
            r_outbus <= '0;
            r_busy   <= 1'b0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_q     <= w_in_mag;
                        r_sq    <= inbus[WIDTH-1];
                        r_dvd   <= inbus;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD_M;
                    end
                end
                S_LOAD_M: begin
                    if (inbus == '0) begin
                        r_dbz    <= 1'b1;
                        r_rem    <= r_dvd;
                        r_outbus <= '1;
                        r_done   <= 1'b1;
                        r_state  <= S_OUT_Q;
                    end else begin
                        r_m     <= w_in_mag;
                        r_sm    <= inbus[WIDTH-1];
                        r_a     <= '0;
                        r_cnt   <= '0;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_a   <= w_a_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Outputs are loaded one state early so done/outbus come straight from flops.
                    r_ovf    <= w_ovf;
                    r_rem    <= w_rem;
                    r_outbus <= w_quo;
                    r_done   <= 1'b1;
                    r_state  <= S_OUT_Q;
                end
                S_OUT_Q: begin
                    r_outbus <= r_rem;
                    r_state  <= S_OUT_R;
                end
                S_OUT_R: begin
                    r_done   <= 1'b0;
                    r_outbus <= '0;
                    r_busy   <= 1'b0;
                    r_dbz    <= 1'b0;
                    r_ovf    <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign done   = r_done;
    assign outbus = r_outbus;
    assign busy   = r_busy;
    assign dbz    = r_dbz;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: directed vector table, randomized operations
// against a plain-arithmetic reference, and multi-cycle reset/enable sequences.
module tb_booth_divider;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] inbus;
    logic       done;
    logic [7:0] outbus;
    logic       busy;
    logic       dbz;
    logic       ovf;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    booth_divider #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .inbus  (inbus),
        .done   (done),
        .outbus (outbus),
        .busy   (busy),
        .dbz    (dbz),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] quo;
        logic [7:0] rem;
        logic       dz;
        logic       ov;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: act=0x%0h req=0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: signed division truncating toward zero, remainder with the dividend's sign.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            q  = 8'hFF;
            r  = a;
            dz = 1'b1;
        end else if (sa == -128 && sb == -1) begin
            q  = 8'h80;
            r  = 8'h00;
            ov = 1'b1;
        end else begin
            q = 8'(sa / sb);
            r = 8'(sa % sb);
        end
    endfunction

    task automatic run_op(input logic [7:0] dvd, input logic [7:0] dvs, input int pulse_at,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic dz, output logic ov, output int lat);
        int e0;
        bit seen;
        @(negedge clk);
        enable = 1'b1;
        inbus  = dvd;
        e0     = cyc + 1;
        @(negedge clk);
        enable = 1'b0;
        inbus  = dvs;
        @(negedge clk);
        inbus = 8'($urandom);
        seen  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            enable = (pulse_at > 0) && (cyc - e0 == pulse_at - 1);
            @(negedge clk);
            inbus = 8'($urandom);
        end
        enable = 1'b0;
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
        end
        lat = cyc - e0;
        q   = outbus;
        dz  = dbz;
        ov  = ovf;
        @(negedge clk);
        chk("done_on_rem", {31'd0, done}, 32'd1);
        r = outbus;
        @(negedge clk);
        chk("idle_after", {20'd0, busy, done, dbz, ovf, outbus}, 32'd0);
    endtask

    logic [7:0] q, r, eq, er;
    logic       dz, ov, edz, eov;
    int         lat;
    int         cnt;
    int         e0;
    int         rises;
    logic       prev;
    logic [7:0] bdvd[3];
    logic [7:0] bdvs[3];
    logic [7:0] bq[3];
    logic [7:0] br[3];

    initial begin
        tbl[0]  = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};
        tbl[1]  = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};
        tbl[2]  = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};
        tbl[3]  = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1};
        tbl[4]  = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0};
        tbl[6]  = '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0};
        tbl[7]  = '{8'hFF, 8'h02, 8'h00, 8'hFF, 1'b0, 1'b0};
        tbl[8]  = '{8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{8'h81, 8'hFF, 8'h7F, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1'b0};

        rst    = 1'b1;
        enable = 1'b0;
        inbus  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_state", {20'd0, busy, done, dbz, ovf, outbus}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].dvd, tbl[i].dvs, 0, q, r, dz, ov, lat);
            chk($sformatf("tbl%0d_quo", i), q, tbl[i].quo);
            chk($sformatf("tbl%0d_rem", i), r, tbl[i].rem);
            chk($sformatf("tbl%0d_dbz", i), dz, tbl[i].dz);
            chk($sformatf("tbl%0d_ovf", i), ov, tbl[i].ov);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].dz ? 32'd1 : 32'd10);
        end

        for (int i = 0; i < 60; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom);
            b = 8'($urandom);
            if (i % 8 == 0) b = 8'h00;
            if (i % 11 == 0) a = 8'h80;
            if (i % 13 == 0) b = 8'hFF;
            model(a, b, eq, er, edz, eov);
            run_op(a, b, 0, q, r, dz, ov, lat);
            chk($sformatf("rnd%0d_quo %0h/%0h", i, a, b), q, eq);
            chk($sformatf("rnd%0d_rem %0h/%0h", i, a, b), r, er);
            chk($sformatf("rnd%0d_dbz", i), dz, edz);
            chk($sformatf("rnd%0d_ovf", i), ov, eov);
            chk($sformatf("rnd%0d_lat", i), lat, edz ? 32'd1 : 32'd10);
        end

        // Reset asserted during the 4th ITER cycle.
        @(negedge clk);
        enable = 1'b1;
        inbus  = 8'h64;
        @(negedge clk);
        enable = 1'b0;
        inbus  = 8'h07;
        repeat (4) @(negedge clk);
        chk("busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("after_rst", {21'd0, busy, done, dbz, outbus}, 32'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("no_partial_after_rst", cnt, 32'd0);
        run_op(8'h64, 8'h07, 0, q, r, dz, ov, lat);
        chk("post_rst_quo", q, 8'h0E);
        chk("post_rst_rem", r, 8'h02);
        chk("post_rst_lat", lat, 32'd10);

        // Enable pulse at E0+3 must be ignored.
        run_op(8'h64, 8'h07, 3, q, r, dz, ov, lat);
        chk("pulse_quo", q, 8'h0E);
        chk("pulse_rem", r, 8'h02);
        chk("pulse_lat", lat, 32'd10);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("pulse_no_second_op", cnt, 32'd0);

        // Enable held high across three operations.
        bdvd[0] = 8'h64; bdvs[0] = 8'h07;
        bdvd[1] = 8'h9C; bdvs[1] = 8'h07;
        bdvd[2] = 8'h64; bdvs[2] = 8'hF9;
        for (int i = 0; i < 3; i++) model(bdvd[i], bdvs[i], bq[i], br[i], edz, eov);
        @(negedge clk);
        enable = 1'b1;
        inbus  = bdvd[0];
        e0     = cyc + 1;
        prev   = 1'b0;
        rises  = 0;
        for (int d = 0; d < 39; d++) begin
            int idx;
            int ph;
            @(negedge clk);
            if (done && !prev) begin
                if (rises < 3) begin
                    chk($sformatf("b2b%0d_rise_at", rises), cyc - e0, 10 + 13 * rises);
                    chk($sformatf("b2b%0d_quo", rises), outbus, bq[rises]);
                end
                rises++;
            end else if (done && prev && rises >= 1 && rises <= 3) begin
                chk($sformatf("b2b%0d_rem", rises - 1), outbus, br[rises - 1]);
            end
            prev = done;
            idx  = (d + 1) / 13;
            ph   = (d + 1) % 13;
            if (ph == 0 && idx < 3) inbus = bdvd[idx];
            else if (ph == 1 && idx < 3) inbus = bdvs[idx];
            else inbus = 8'($urandom);
            if (d == 38) enable = 1'b0;
        end
        chk("b2b_rises", rises, 32'd3);
        repeat (2) @(negedge clk);
        chk("b2b_idle_end", {30'd0, busy, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
